// File: rtl/fft_power_peak.sv
// Bin power (re^2 + im^2) with a 2-stage pipeline and a per-frame peak tracker.
// Optional threshold flag on the reported peak is built when PEAK_THRESH_EN is defined.
module fft_power_peak #(
    parameter  int N          = 8,
    parameter  int DATA_WIDTH = 16,
    localparam int BIN_W      = $clog2(N),
    localparam int PWR_W      = 2 * DATA_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    input  logic                         in_valid,
    input  logic                         clear,
`ifdef PEAK_THRESH_EN
    input  logic        [PWR_W-1:0]      thresh,
    output logic                         peak_over,
`endif
    output logic        [PWR_W-1:0]      pwr_out,
    output logic        [BIN_W-1:0]      pwr_bin,
    output logic                         pwr_valid,
    output logic        [PWR_W-1:0]      peak_pwr,
    output logic        [BIN_W-1:0]      peak_bin,
    output logic                         peak_valid,
    output logic        [15:0]           frame_cnt,
    output logic        [1:0]            dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, REPORT = 2'd2} state_t;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [BIN_W-1:0]          r_bin_cnt;
    logic [2*DATA_WIDTH-1:0]   r_s1_rr;
    logic [2*DATA_WIDTH-1:0]   r_s1_ii;
    logic [BIN_W-1:0]          r_s1_bin;
    logic                      r_s1_valid;
    logic [PWR_W-1:0]          r_run_pwr;
    logic [BIN_W-1:0]          r_run_bin;
    logic signed [2*DATA_WIDTH-1:0] w_rr;
    logic signed [2*DATA_WIDTH-1:0] w_ii;
    logic                      w_beat;
    logic                      w_load;
    logic                      w_upd;
    logic                      w_report;
    logic [PWR_W-1:0]          w_max_pwr;
    logic [BIN_W-1:0]          w_max_bin;

    assign w_rr      = in_real * in_real;
    assign w_ii      = in_imag * in_imag;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin_cnt <= '0;
        end else if (clear) begin
            r_bin_cnt <= '0;
        end else if (in_valid) begin
            r_bin_cnt <= (r_bin_cnt == LAST_BIN) ? '0 : r_bin_cnt + 1'b1;
        end
    end

    // Squares are never negative, so they are carried unsigned into the adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_rr    <= '0;
            r_s1_ii    <= '0;
            r_s1_bin   <= '0;
            r_s1_valid <= 1'b0;
            pwr_out    <= '0;
            pwr_bin    <= '0;
            pwr_valid  <= 1'b0;
        end else begin
            r_s1_valid <= in_valid & ~clear;
            pwr_valid  <= r_s1_valid & ~clear;
            if (in_valid) begin
                r_s1_rr  <= $unsigned(w_rr);
                r_s1_ii  <= $unsigned(w_ii);
                r_s1_bin <= r_bin_cnt;
            end
            if (r_s1_valid) begin
                pwr_out <= {1'b0, r_s1_rr} + {1'b0, r_s1_ii};
                pwr_bin <= r_s1_bin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_beat = pwr_valid & ~clear;

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_upd    = 1'b0;
        w_report = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_beat && pwr_bin == '0) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_beat) begin
                    w_upd = (pwr_out > r_run_pwr);
                    if (pwr_bin == LAST_BIN) begin
                        w_report = 1'b1;
                        w_next   = REPORT;
                    end
                end
            end
            REPORT: begin
                if (w_beat && pwr_bin == '0) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (clear) begin
            w_next   = IDLE;
            w_load   = 1'b0;
            w_upd    = 1'b0;
            w_report = 1'b0;
        end
    end

    // The last bin is folded in combinationally so the report does not wait a cycle.
    assign w_max_pwr = w_upd ? pwr_out : r_run_pwr;
    assign w_max_bin = w_upd ? pwr_bin : r_run_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_pwr  <= '0;
            r_run_bin  <= '0;
            peak_pwr   <= '0;
            peak_bin   <= '0;
            peak_valid <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            peak_valid <= w_report;
            if (w_load) begin
                r_run_pwr <= pwr_out;
                r_run_bin <= pwr_bin;
            end else if (w_upd) begin
                r_run_pwr <= pwr_out;
                r_run_bin <= pwr_bin;
            end
            if (w_report) begin
                peak_pwr  <= w_max_pwr;
                peak_bin  <= w_max_bin;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef PEAK_THRESH_EN
    // Compared against the freshly reported peak during the REPORT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_over <= 1'b0;
        end else if (peak_valid) begin
            peak_over <= (peak_pwr >= thresh);
        end
    end
`endif

endmodule

// File: tb/tb_fft_power_peak.sv
// Scoreboard bench for fft_power_peak: directed frames with hand-computed powers and peaks.
// Handshake: pwr_* is consumed on every cycle pwr_valid is high; peak_* on every peak_valid pulse.
module tb_fft_power_peak;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int BW = 3;
  localparam int PW = 33;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] in_real = '0;
  logic signed [DW-1:0] in_imag = '0;
  logic                 in_valid = 1'b0;
  logic                 clear = 1'b0;
  logic [PW-1:0]        pwr_out;
  logic [BW-1:0]        pwr_bin;
  logic                 pwr_valid;
  logic [PW-1:0]        peak_pwr;
  logic [BW-1:0]        peak_bin;
  logic                 peak_valid;
  logic [15:0]          frame_cnt;
  logic [1:0]           dbg_state;
`ifdef PEAK_THRESH_EN
  logic [PW-1:0]        thresh = 33'd100;
  logic                 peak_over;
`endif

  fft_power_peak #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .in_valid   (in_valid),
    .clear      (clear),
`ifdef PEAK_THRESH_EN
    .thresh     (thresh),
    .peak_over  (peak_over),
`endif
    .pwr_out    (pwr_out),
    .pwr_bin    (pwr_bin),
    .pwr_valid  (pwr_valid),
    .peak_pwr   (peak_pwr),
    .peak_bin   (peak_bin),
    .peak_valid (peak_valid),
    .frame_cnt  (frame_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [PW-1:0] exp_q[$];
  logic [BW-1:0] exp_bin_q[$];
  logic [PW-1:0] pk_pwr_q[$];
  logic [BW-1:0] pk_bin_q[$];
  logic [15:0]   pk_cnt_q[$];
  logic [BW-1:0] exp_bin = '0;
  int            n_vec = 0;
  int            n_err = 0;
  int            n_pwr_beats = 0;
  logic          prev_pv = 1'b0;

  // frame A powers {1,4,9,100,16,100,0,2}; frame B has (-32768,-32768) at bin 6
  int            a_re[8] = '{1, 0, 3, 6, 4, 0, 0, 1};
  int            a_im[8] = '{0, 2, 0, 8, 0, 10, 0, 1};
  logic [63:0]   a_p[8]  = '{1, 4, 9, 100, 16, 100, 0, 2};
  int            b_re[8] = '{3, 1, 2, 0, 5, 7, -32768, -1};
  int            b_im[8] = '{4, 0, 0, 3, 0, 0, -32768, -1};
  logic [63:0]   b_p[8]  = '{25, 1, 4, 9, 25, 49, 64'd2147483648, 2};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic beat(input int re, input int im, input logic [63:0] p);
    in_real  = DW'(re);
    in_imag  = DW'(im);
    in_valid = 1'b1;
    exp_q.push_back(p[PW-1:0]);
    exp_bin_q.push_back(exp_bin);
    exp_bin  = exp_bin + 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_a(input int gap_max, input logic [15:0] cnt);
    pk_pwr_q.push_back(33'd100);
    pk_bin_q.push_back(3'd3);
    pk_cnt_q.push_back(cnt);
    for (int i = 0; i < N; i++) begin
      beat(a_re[i], a_im[i], a_p[i]);
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
    end
  endtask

  task automatic frame_b(input logic [15:0] cnt);
    pk_pwr_q.push_back(33'd2147483648);
    pk_bin_q.push_back(3'd6);
    pk_cnt_q.push_back(cnt);
    for (int i = 0; i < N; i++) beat(b_re[i], b_im[i], b_p[i]);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && pk_pwr_q.size() == 0) break;
      @(posedge clk);
    end
    idle(2);
    check("drain_pending", exp_q.size() + pk_pwr_q.size(), 0);
  endtask

  task automatic pulse_clear(input logic with_beat);
    clear    = 1'b1;
    in_valid = with_beat;
    in_real  = 16'sd9;
    in_imag  = 16'sd9;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    exp_bin  = '0;
  endtask

  // monitor: pops expectations whenever the DUT presents output
  always @(negedge clk) begin
    if (rst_n) begin
      if (pwr_valid) begin
        n_pwr_beats++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pwr_unexpected: got pwr %0d bin %0d, none expected", pwr_out, pwr_bin);
        end else begin
          check("pwr_out", pwr_out, exp_q.pop_front());
          check("pwr_bin", pwr_bin, exp_bin_q.pop_front());
        end
      end
      if (peak_valid) begin
        if (pk_pwr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL peak_unexpected: got peak %0d bin %0d, none expected", peak_pwr, peak_bin);
        end else begin
          check("peak_pwr", peak_pwr, pk_pwr_q.pop_front());
          check("peak_bin", peak_bin, pk_bin_q.pop_front());
          check("frame_cnt", frame_cnt, pk_cnt_q.pop_front());
        end
        if (prev_pv) begin
          n_vec++;
          n_err++;
          $display("FAIL peak_pulse_width: got 2+ cycles, expected 1");
        end
      end
      prev_pv = peak_valid;
    end else begin
      prev_pv = 1'b0;
    end
  end

  initial begin
    int n0;
    // reset state
    idle(3);
    check("rst_pwr_valid", pwr_valid, 0);
    check("rst_pwr_out", pwr_out, 0);
    check("rst_peak_pwr", peak_pwr, 0);
    check("rst_peak_valid", peak_valid, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    idle(2);

    // single beat (3,4) -> 25 at bin 0, exactly 2 cycles later
    beat(3, 4, 25);
    @(negedge clk);
    check("lat_cycle1_valid", pwr_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", pwr_valid, 1);
    drain();
    pulse_clear(1'b0);
    idle(1);
    check("clear_state_idle", dbg_state, 0);

    // two back-to-back frames
    n0 = n_pwr_beats;
    frame_a(0, 16'd1);
    frame_b(16'd2);
    drain();
    check("beats_two_frames", n_pwr_beats - n0, 16);
    idle(5);
    check("hold_peak_pwr", peak_pwr, 64'd2147483648);
    check("hold_peak_bin", peak_bin, 6);
    check("hold_frame_cnt", frame_cnt, 2);

    // frame with random gaps
`ifdef PEAK_THRESH_EN
    thresh = 33'd100;
`endif
    frame_a(3, 16'd3);
    drain();
`ifdef PEAK_THRESH_EN
    check("peak_over_t100", peak_over, 1);
    thresh = 33'd101;
`endif

    // abort after bin 4 (clear coincides with a discarded beat), then a full frame
    for (int i = 0; i < 5; i++) beat(b_re[i], b_im[i], b_p[i]);
    drain();
    pulse_clear(1'b1);
    frame_a(0, 16'd4);
    drain();
    check("after_clear_frame_cnt", frame_cnt, 4);
`ifdef PEAK_THRESH_EN
    check("peak_over_t101", peak_over, 0);
`endif

    // reset mid-frame discards the partial frame
    for (int i = 0; i < 3; i++) beat(b_re[i], b_im[i], b_p[i]);
    drain();
    rst_n = 1'b0;
    #1;
    check("midrst_peak_pwr", peak_pwr, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_state", dbg_state, 0);
    idle(1);
    rst_n   = 1'b1;
    exp_bin = '0;
    idle(1);
    frame_a(1, 16'd1);
    drain();
    check("end_state_idle", dbg_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fft_power_peak.md
FFT_POWER_PEAK -- requirements
Module: fft_power_peak

Interface
REQ-001 SHALL have parameter N, default 8, meaning FFT frame length in bins (power of two, at least 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning signed width of the input real and imaginary parts.
REQ-003 SHALL derive localparams BIN_W = log2(N) and PWR_W = 2*DATA_WIDTH+1.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_real, in_imag  input  DATA_WIDTH  signed bin value from the upstream FFT output port, in bin order.
REQ-007 in_valid  input  1  bin present this cycle; there is no backpressure and gaps are allowed.
REQ-008 clear  input  1  synchronous abort of the current frame.
REQ-009 pwr_out  output  PWR_W  unsigned bin power, real squared plus imaginary squared.
REQ-010 pwr_bin  output  BIN_W  bin index of pwr_out.
REQ-011 pwr_valid  output  1  pwr_out and pwr_bin valid.
REQ-012 peak_pwr  output  PWR_W  maximum power of the last completed frame.
REQ-013 peak_bin  output  BIN_W  index of that maximum.
REQ-014 peak_valid  output  1  one-cycle pulse when peak_pwr and peak_bin update.
REQ-015 frame_cnt  output  16  completed frames, wraps from 65535 to 0.

Function
REQ-016 SHALL keep an input bin counter that captures each in_valid beat as bin k, counts 0 to N-1, then wraps to 0.
REQ-017 Pipeline stage 1 SHALL register the full-precision products real*real and imag*imag, plus k and a valid flag.
REQ-018 Stage 2 SHALL register their sum into pwr_out, pwr_bin and pwr_valid.
REQ-019 Latency SHALL be exactly 2 cycles from an in_valid beat to pwr_valid, with one output per input and no drops at full rate.
REQ-020 Arithmetic SHALL be exact with no saturation; for example, (-32768,-32768) produces 2147483648.
REQ-021 The peak tracker SHALL have states IDLE, RUN and REPORT, driven by stage-2 beats.
REQ-022 IDLE to RUN: on a stage-2 beat with pwr_bin 0, load that beat as the running maximum and its index.
REQ-023 RUN: on each later beat, replace the running maximum only if the new power is strictly greater; on a tie the lower index is kept.
REQ-024 RUN to REPORT: after the beat with pwr_bin N-1 has been compared, copy the running maximum to peak_pwr and peak_bin, pulse peak_valid for 1 cycle, and increment frame_cnt.
REQ-025 REPORT lasts one cycle; a stage-2 beat in that cycle with pwr_bin 0 starts the next frame (load and go to RUN), otherwise the tracker returns to IDLE.
REQ-026 Back-to-back frames with no gap SHALL lose no bins and no reports.
REQ-027 peak_pwr and peak_bin SHALL hold their values between reports.
REQ-028 clear SHALL zero the input bin counter, flush both pipeline valid flags and send the tracker to IDLE.
REQ-029 clear SHALL leave peak_pwr, peak_bin and frame_cnt unchanged and raise no peak_valid.
REQ-030 If clear and in_valid are high in the same cycle, clear wins and the beat is discarded.

Reset
REQ-031 While rst_n is low, all outputs, the counters, the pipeline registers and the running maximum SHALL be 0 and the tracker SHALL be in IDLE.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release the first in_valid beat is bin 0.

Configuration
REQ-033 Macro PEAK_THRESH_EN, when defined, SHALL add input thresh (PWR_W bits) and output peak_over (1 bit).
REQ-034 With PEAK_THRESH_EN, peak_over SHALL be set when peak_valid pulses, to 1 if peak_pwr >= thresh (sampled in the report cycle), and then hold; it resets to 0.
REQ-035 Without PEAK_THRESH_EN, neither port nor the comparator SHALL exist; all other behaviour is identical.

Verification
REQ-036 Single beat (3,4) -> pwr_out=25, pwr_bin=0, pwr_valid high exactly 2 cycles later.
REQ-037 Continuous frame with powers {1,4,9,100,16,100,0,2} -> peak_valid pulse after bin 7, peak_pwr=100, peak_bin=3 (tie kept at lower index), frame_cnt=1.
REQ-038 Two frames back-to-back, the second with (-32768,-32768) at bin 6 -> second report peak_pwr=2147483648, peak_bin=6, frame_cnt=2, and 16 pwr_valid beats in total.
REQ-039 Frame with random in_valid gaps -> bin indices continuous and the report matches the gap-free result.
REQ-040 clear asserted after bin 4 and then a full frame -> no report for the aborted frame; the next report covers only the new frame; frame_cnt increments by 1.
REQ-041 PEAK_THRESH_EN with thresh=100 -> the REQ-037 frame gives peak_over=1; with thresh=101 it gives peak_over=0.
